// File: rtl/dbg_pkg.sv
// dbg_pkg: view mode type, blank pattern and hex-to-7-segment decoder shared by dbg_seg_display
package dbg_pkg;
  typedef enum logic {VIEW_IR, VIEW_PC} view_mode_t;
  localparam logic [6:0] SEG_BLANK = 7'h7f;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and single-cycle press pulse for a raw button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, differ, done;
  always_comb begin
    sync_d = {sync_q[0], btn};
    differ = sync_q[1] != level_q;
    done = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = differ && !done ? cnt_q + 1'b1 : '0;
    level_d = done ? sync_q[1] : level_q;
    press_d = done && sync_q[1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/dbg_seg_display.sv
// dbg_seg_display: multiplexed 4-digit 7-segment view of CPU state/pc/ir with mode and freeze buttons
module dbg_seg_display
  import dbg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  state_dbg,
  input  logic [7:0]  pc_dbg,
  input  logic [15:0] ir_dbg,
  input  logic        btn_mode,
  input  logic        btn_freeze,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  logic mode_press, freeze_press;
  view_mode_t mode_q, mode_d;
  logic frozen_q, frozen_d, active_q, active_d, dp_q, dp_d, wrap, blank;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] st_q, st_d;
  logic [7:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d, nib;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .btn(btn_mode), .press(mode_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_freeze (
    .clk(clk), .reset(reset), .btn(btn_freeze), .press(freeze_press)
  );
  always_comb begin
    mode_d = mode_press ? (mode_q == VIEW_IR ? VIEW_PC : VIEW_IR) : mode_q;
    frozen_d = frozen_q ^ freeze_press;
    {st_d, pc_d, ir_d} = frozen_q ? {st_q, pc_q, ir_q} : {state_dbg, pc_dbg, ir_dbg};
    wrap = ref_q == RW'(REFRESH_DIV - 1);
    ref_d = wrap ? '0 : ref_q + 1'b1;
    active_d = active_q | wrap;
    idx_d = wrap && active_q ? idx_q + 2'd1 : idx_q;
    blank = mode_q == VIEW_PC && idx_q == 2'd1;
    nib = mode_q == VIEW_IR ? ir_q[{idx_q, 2'b00} +: 4] :
          idx_q == 2'd3 ? pc_q[7:4] :
          idx_q == 2'd2 ? pc_q[3:0] : {1'b0, st_q};
    an_d = active_q ? ~(4'b0001 << idx_q) : 4'hf;
    seg_d = active_q && !blank ? hex_to_seg(nib) : SEG_BLANK;
    dp_d = !(active_q && idx_q == 2'd0 && frozen_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= VIEW_IR;
      frozen_q <= 1'b0;
      active_q <= 1'b0;
      ref_q <= '0;
      idx_q <= '0;
      st_q <= '0;
      pc_q <= '0;
      ir_q <= '0;
      an_q <= 4'hf;
      seg_q <= SEG_BLANK;
      dp_q <= 1'b1;
    end else begin
      mode_q <= mode_d;
      frozen_q <= frozen_d;
      active_q <= active_d;
      ref_q <= ref_d;
      idx_q <= idx_d;
      st_q <= st_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
    end
  end
  assign seg = seg_q;
  assign an = an_q;
  assign dp = dp_q;
endmodule

// File: tb/tb_dbg_seg_display.sv
// tb_dbg_seg_display: scoreboard bench comparing dbg_seg_display outputs every cycle with a reference model
module tb_dbg_seg_display;
  localparam int DIV = 4;
  localparam int DEB = 8;
  logic clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_freeze = 1'b0;
  logic [2:0] state_dbg = '0;
  logic [7:0] pc_dbg = '0;
  logic [15:0] ir_dbg = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic dp;
  int tests = 0, fails = 0, cyc = 0;
  logic [11:0] exp_q [$];
  logic [6:0] hex_t [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  int m_n;
  logic m_pc_view, m_frozen;
  logic [2:0] m_st;
  logic [7:0] m_pc;
  logic [15:0] m_ir;
  logic [1:0] m_s0, m_s1, m_lvl, m_pm;
  int m_run [2];
  dbg_seg_display #(.REFRESH_DIV(DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .state_dbg(state_dbg), .pc_dbg(pc_dbg), .ir_dbg(ir_dbg),
    .btn_mode(btn_mode), .btn_freeze(btn_freeze), .seg(seg), .an(an), .dp(dp)
  );
  always #5 clk = ~clk;
  task automatic model_edge();
    int d;
    logic [3:0] nib;
    if (reset) begin
      exp_q.push_back({4'hf, 7'h7f, 1'b1});
      m_n = 0;
      m_pc_view = 1'b0;
      m_frozen = 1'b0;
      m_st = '0;
      m_pc = '0;
      m_ir = '0;
      m_s0 = '0;
      m_s1 = '0;
      m_lvl = '0;
      m_pm = '0;
      m_run = '{0, 0};
      return;
    end
    if (m_n < DIV) exp_q.push_back({4'hf, 7'h7f, 1'b1});
    else begin
      d = (m_n / DIV - 1) % 4;
      nib = !m_pc_view ? m_ir[4*d +: 4] : d == 3 ? m_pc[7:4] : d == 2 ? m_pc[3:0] : {1'b0, m_st};
      exp_q.push_back({~(4'b0001 << d), (m_pc_view && d == 1) ? 7'h7f : hex_t[nib], !(d == 0 && m_frozen)});
    end
    if (!m_frozen) begin
      m_st = state_dbg;
      m_pc = pc_dbg;
      m_ir = ir_dbg;
    end
    m_pc_view ^= m_pm[0];
    m_frozen ^= m_pm[1];
    for (int i = 0; i < 2; i++) begin
      m_pm[i] = 1'b0;
      if (m_s1[i] == m_lvl[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = m_s1[i];
          m_run[i] = 0;
          m_pm[i] = m_lvl[i];
        end
      end
    end
    m_s1 = m_s0;
    m_s0 = {btn_freeze, btn_mode};
    m_n++;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask
  task automatic cycles(input int n);
    repeat (n) step();
  endtask
  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({an, seg, dp} !== e) begin
        fails++;
        $display("FAIL disp @cycle %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 cyc, an, seg, dp, e[11:8], e[7:1], e[0]);
      end
    end
  end
  initial begin
    cycles(3);
    reset = 1'b0;
    ir_dbg = 16'hA3F0;
    cycles(40);
    pc_dbg = 8'h2C;
    state_dbg = 3'd5;
    btn_mode = 1'b1;
    cycles(20);
    btn_mode = 1'b0;
    cycles(40);
    for (int i = 0; i < 10; i++) begin
      btn_mode = ~btn_mode;
      cycles(3);
    end
    btn_mode = 1'b0;
    cycles(30);
    ir_dbg = 16'h1234;
    btn_freeze = 1'b1;
    cycles(12);
    btn_freeze = 1'b0;
    cycles(30);
    ir_dbg = 16'hFFFF;
    cycles(30);
    btn_freeze = 1'b1;
    cycles(12);
    btn_freeze = 1'b0;
    cycles(30);
    btn_mode = 1'b1;
    btn_freeze = 1'b1;
    cycles(10);
    btn_mode = 1'b0;
    btn_freeze = 1'b0;
    cycles(40);
    btn_mode = 1'b1;
    btn_freeze = 1'b1;
    cycles(5);
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_freeze = 1'b0;
    cycles(3);
    reset = 1'b0;
    cycles(40);
    for (int i = 0; i < 3000; i++) begin
      state_dbg = 3'($urandom);
      pc_dbg = 8'($urandom);
      ir_dbg = 16'($urandom);
      if ($urandom_range(0, 7) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 7) == 0) btn_freeze = ~btn_freeze;
      reset = $urandom_range(0, 599) == 0;
      step();
    end
    reset = 1'b0;
    cycles(10);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
